case_7_sdiv_13s_6s_8_seq: RTL

Sequential signed divider that inverts `case_7_mul_8s_6s_13`: it takes a 13-bit signed product-width dividend and a 6-bit signed divisor, and returns the 8-bit signed quotient and 6-bit signed remainder. It sits in the case_7 datapath wherever a scaled value must be reduced back to operand width. It runs as a radix-2 restoring divider under a start/done handshake, one quotient bit per cycle.

---
 rtl/case_7_sdiv_pkg.sv | 18 +
 rtl/case_7_sdiv_step.sv | 23 ++
 rtl/case_7_sdiv_13s_6s_8_seq.sv | 127 ++++++++++++
 3 files changed

// File: rtl/case_7_sdiv_pkg.sv
// Shared widths and FSM encoding for the case_7 sequential signed divider.
package case_7_sdiv_pkg;

  localparam int unsigned din0_WIDTH = 13;
  localparam int unsigned din1_WIDTH = 6;
  localparam int unsigned dout_WIDTH = 8;
  localparam int unsigned CntWidth   = $clog2(din0_WIDTH + 1);

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StCalc = 2'd1;
  localparam state_t StFix  = 2'd2;
  localparam state_t StDone = 2'd3;

  localparam logic [CntWidth-1:0] CntLast = CntWidth'(din0_WIDTH - 1);

endpackage

// File: rtl/case_7_sdiv_step.sv
// One combinational radix-2 restoring step: shift in a dividend bit, subtract if it fits.
module case_7_sdiv_step
  import case_7_sdiv_pkg::*;
(
  input  logic [din1_WIDTH:0]   prem,
  input  logic                  dvd_bit,
  input  logic [din1_WIDTH-1:0] dsr,
  output logic [din1_WIDTH:0]   prem_next,
  output logic                  qbit
);

  logic [din1_WIDTH:0] shifted;
  logic [din1_WIDTH:0] diff;

  always_comb begin
    shifted   = {prem[din1_WIDTH-1:0], dvd_bit};
    diff      = shifted - {1'b0, dsr};
    // A set top bit means the shifted value overflowed the window, so it exceeds any divisor.
    qbit      = prem[din1_WIDTH] | (shifted >= {1'b0, dsr});
    prem_next = qbit ? diff : shifted;
  end

endmodule

// File: rtl/case_7_sdiv_13s_6s_8_seq.sv
// Sequential 13s/6s signed divider, 8-bit quotient, start/done handshake.
// Define CASE_7_SDIV_REM_EN to compute and drive the remainder; otherwise rem is 0.
module case_7_sdiv_13s_6s_8_seq
  import case_7_sdiv_pkg::*;
(
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  ready,
  output logic                  done,
  output logic [dout_WIDTH-1:0] quot,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  dbz,
  output logic                  ovf
);

  state_t                state_q;
  logic [CntWidth-1:0]   cnt_q;
  logic [din0_WIDTH-1:0] dvd_q;
  logic [din1_WIDTH-1:0] dsr_q;
  logic [din1_WIDTH:0]   prem_q;
  logic                  sign_q_q;
  logic [dout_WIDTH-1:0] quot_q;
  logic                  dbz_q;
  logic                  ovf_q;

  logic [din0_WIDTH-1:0] a_mag;
  logic [din1_WIDTH-1:0] b_mag;
  logic [din1_WIDTH:0]   prem_next;
  logic                  qbit;
  logic [din0_WIDTH:0]   qfull;
  logic                  ovf_fix;

  case_7_sdiv_step u_step (
    .prem      (prem_q),
    .dvd_bit   (dvd_q[din0_WIDTH-1]),
    .dsr       (dsr_q),
    .prem_next (prem_next),
    .qbit      (qbit)
  );

  always_comb begin
    a_mag   = din0[din0_WIDTH-1] ? (~din0 + 1'b1) : din0;
    b_mag   = din1[din1_WIDTH-1] ? (~din1 + 1'b1) : din1;
    qfull   = sign_q_q ? (~{1'b0, dvd_q} + 1'b1) : {1'b0, dvd_q};
    // Fits in dout_WIDTH only if all bits above the quotient's sign bit match it.
    ovf_fix = ~((&qfull[din0_WIDTH:dout_WIDTH-1]) | ~(|qfull[din0_WIDTH:dout_WIDTH-1]));
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      prem_q   <= '0;
      sign_q_q <= 1'b0;
      quot_q   <= '0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StCalc;
            cnt_q    <= '0;
            dvd_q    <= a_mag;
            dsr_q    <= b_mag;
            prem_q   <= '0;
            sign_q_q <= din0[din0_WIDTH-1] ^ din1[din1_WIDTH-1];
          end
        end
        StCalc: begin
          prem_q <= prem_next;
          dvd_q  <= {dvd_q[din0_WIDTH-2:0], qbit};
          if (cnt_q == CntLast) begin
            cnt_q   <= '0;
            state_q <= StFix;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StFix: begin
          state_q <= StDone;
          dbz_q   <= (dsr_q == '0);
          quot_q  <= (dsr_q == '0) ? '0 : qfull[dout_WIDTH-1:0];
          ovf_q   <= (dsr_q == '0) ? 1'b0 : ovf_fix;
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef CASE_7_SDIV_REM_EN
  logic                  sign_r_q;
  logic [din1_WIDTH-1:0] rem_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      sign_r_q <= 1'b0;
      rem_q    <= '0;
    end else if (state_q == StIdle && start) begin
      sign_r_q <= din0[din0_WIDTH-1];
    end else if (state_q == StFix) begin
      if (dsr_q == '0) begin
        rem_q <= '0;
      end else begin
        rem_q <= sign_r_q ? (~prem_q[din1_WIDTH-1:0] + 1'b1) : prem_q[din1_WIDTH-1:0];
      end
    end
  end

  assign rem = rem_q;
`else
  assign rem = '0;
`endif

  assign ready = (state_q == StIdle);
  assign done  = (state_q == StDone);
  assign quot  = quot_q;
  assign dbz   = dbz_q;
  assign ovf   = ovf_q;

endmodule
